// File: rtl/hansen_mem_ctrl.sv
// hansen_mem_ctrl: Hansen core memory port controller serving a word RAM and an MMIO bank (LED, cycle counter, halt mailbox); optional macro HANSEN_MEM_BYTE_EN_EN enables byte-lane RAM stores
module hansen_mem_ctrl #(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] MMIO_BASE   = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [7:0]  dbg_led,
    output logic        halt,
    output logic [31:0] halt_code
);
    localparam int AW = $clog2(DEPTH_WORDS);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
    state_t      state;
    logic [2:0]  wcnt;
    logic        lat_we;
    logic [31:0] lat_addr, lat_wdata, lat_cyc;
    logic [3:0]  lat_be;
    logic [31:0] cyc_cnt;
    logic        idle, go, cur_we, ram_hit, mmio_hit, err;
    logic [31:0] cur_addr, cur_wdata, cur_cyc, rdata;
    logic [3:0]  cur_be;
    logic [1:0]  off;
    logic [AW-1:0] idx;
    logic [31:0] mem [DEPTH_WORDS];
    assign req_ready = idle;
    // With zero wait states the access happens on the acceptance edge, so decode sees the live request in IDLE
    always_comb begin
        idle      = state == S_IDLE;
        cur_we    = idle ? req_we : lat_we;
        cur_addr  = idle ? req_addr : lat_addr;
        cur_wdata = idle ? req_wdata : lat_wdata;
        cur_be    = idle ? req_be : lat_be;
        cur_cyc   = idle ? cyc_cnt : lat_cyc;
        go        = idle ? (req_valid && WAIT_STATES == 0) : (state == S_WAIT && int'(wcnt) == WAIT_STATES - 1);
        off       = cur_addr[3:2];
        idx       = cur_addr[AW+1:2];
        ram_hit   = cur_addr < 32'(DEPTH_WORDS * 4);
        mmio_hit  = !ram_hit && cur_addr[31:4] == MMIO_BASE[31:4];
        err       = cur_addr[1:0] != 2'd0 || !(ram_hit || (mmio_hit && off != 2'd3));
        rdata     = ram_hit ? mem[idx] : off == 2'd0 ? {24'b0, dbg_led} : off == 2'd1 ? cur_cyc : halt_code;
    end
`ifndef HANSEN_MEM_BYTE_EN_EN
    logic unused_be;
    assign unused_be = ^cur_be;
`endif
    // Request FSM, response registers and MMIO side effects
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            wcnt      <= '0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_be    <= '0;
            lat_cyc   <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            dbg_led   <= '0;
            halt      <= 1'b0;
            halt_code <= '0;
        end else begin
            rsp_valid <= go;
            rsp_err   <= go && err;
            rsp_rdata <= (go && !err && !cur_we) ? rdata : 32'd0;
            if (go && !err && cur_we && mmio_hit && off == 2'd0)
                dbg_led <= cur_wdata[7:0];
            if (go && !err && cur_we && mmio_hit && off == 2'd2) begin
                halt      <= 1'b1;
                halt_code <= cur_wdata;
            end
            case (state)
                S_IDLE:
                    if (req_valid) begin
                        lat_we    <= req_we;
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                        lat_be    <= req_be;
                        lat_cyc   <= cyc_cnt;
                        wcnt      <= '0;
                        state     <= WAIT_STATES == 0 ? S_RESP : S_WAIT;
                    end
                S_WAIT: begin
                    wcnt  <= wcnt + 3'd1;
                    state <= go ? S_RESP : S_WAIT;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
    // RAM store on the edge entering RESP; contents survive reset
    always_ff @(posedge clk) begin
        if (go && reset_n && cur_we && ram_hit && !err) begin
`ifdef HANSEN_MEM_BYTE_EN_EN
            for (int i = 0; i < 4; i++)
                if (cur_be[i]) mem[idx][8*i +: 8] <= cur_wdata[8*i +: 8];
`else
            mem[idx] <= cur_wdata;
`endif
        end
    end
    // Free-running cycle counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc_cnt <= '0;
        else cyc_cnt <= cyc_cnt + 32'd1;
    end
endmodule

// File: tb/tb_hansen_mem_ctrl.sv
// tb_hansen_mem_ctrl: table-driven scoreboard bench for hansen_mem_ctrl (WAIT_STATES=1 main unit, WAIT_STATES=3 reset unit)
module tb_hansen_mem_ctrl;
    localparam int          WS0 = 1;
    localparam logic [31:0] MB  = 32'h8000_0000;
`ifdef HANSEN_MEM_BYTE_EN_EN
    localparam logic [31:0] BE_EXP = 32'h11BB33DD;
`else
    localparam logic [31:0] BE_EXP = 32'hAABBCCDD;
`endif
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] erd;
        logic        eerr;
        logic        chk_rd;
        logic [7:0]  eled;
        logic        ehalt;
        logic [31:0] ecode;
        int          id;
    } vec_t;
    logic clk = 1'b0;
    logic rst0_n, rst1_n, req_valid0, req_valid1, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;
    logic req_ready0, rsp_valid0, rsp_err0, halt0, req_ready1, rsp_valid1, rsp_err1, halt1;
    logic [31:0] rsp_rdata0, halt_code0, rsp_rdata1, halt_code1;
    logic [7:0]  dbg_led0, dbg_led1;
    int total = 0, bad = 0;
    vec_t sb[$];
    vec_t tv[$];
    always #5 clk = ~clk;
    hansen_mem_ctrl #(.DEPTH_WORDS(1024), .WAIT_STATES(WS0), .MMIO_BASE(MB)) u0 (
        .clk(clk), .reset_n(rst0_n), .req_valid(req_valid0), .req_ready(req_ready0),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid0), .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0),
        .dbg_led(dbg_led0), .halt(halt0), .halt_code(halt_code0)
    );
    hansen_mem_ctrl #(.DEPTH_WORDS(1024), .WAIT_STATES(3), .MMIO_BASE(MB)) u1 (
        .clk(clk), .reset_n(rst1_n), .req_valid(req_valid1), .req_ready(req_ready1),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid1), .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1),
        .dbg_led(dbg_led1), .halt(halt1), .halt_code(halt_code1)
    );
    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", n, act, exp);
        end
    endtask
    function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be,
                                input logic [31:0] erd, input logic eerr, input logic chk_rd,
                                input logic [7:0] eled, input logic ehalt, input logic [31:0] ecode);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wdata; v.be = be; v.erd = erd; v.eerr = eerr;
        v.chk_rd = chk_rd; v.eled = eled; v.ehalt = ehalt; v.ecode = ecode; v.id = 0;
        return v;
    endfunction
    // Scoreboard: pop on every response strobe of the main unit
    always @(negedge clk) begin
        vec_t e;
        if (rst0_n && rsp_valid0) begin
            if (sb.size() == 0) chk("sb_unexpected_rsp", 32'd1, 32'd0);
            else begin
                e = sb.pop_front();
                if (e.chk_rd) chk($sformatf("v%0d_rdata", e.id), rsp_rdata0, e.erd);
                chk($sformatf("v%0d_err", e.id), 32'(rsp_err0), 32'(e.eerr));
                chk($sformatf("v%0d_led", e.id), 32'(dbg_led0), 32'(e.eled));
                chk($sformatf("v%0d_halt", e.id), 32'(halt0), 32'(e.ehalt));
                chk($sformatf("v%0d_code", e.id), halt_code0, e.ecode);
            end
        end else if (rst0_n) chk("idle_rsp_zero", rsp_rdata0 | 32'(rsp_err0), 32'd0);
    end
    task automatic xact(input vec_t v, output logic [31:0] rd, output time t);
        int k;
        @(negedge clk);
        for (k = 0; k < 20 && !req_ready0; k++) @(negedge clk);
        req_valid0 = 1'b1; req_we = v.we; req_addr = v.addr; req_wdata = v.wdata; req_be = v.be;
        sb.push_back(v);
        @(posedge clk);
        t = $time;
        #1;
        req_valid0 = 1'b0; req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom; req_be = 4'($urandom);
        for (k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (rsp_valid0) break;
            if (req_ready0) chk($sformatf("v%0d_ready_busy", v.id), 32'd1, 32'd0);
        end
        chk($sformatf("v%0d_latency", v.id), k, WS0 + 1);
        chk($sformatf("v%0d_ready_at_rsp", v.id), 32'(req_ready0), 32'd0);
        rd = rsp_rdata0;
        @(negedge clk);
        chk($sformatf("v%0d_ready_back", v.id), 32'(req_ready0), 32'd1);
    endtask
    task automatic u1_op(input logic we, input logic [31:0] a, input logic [31:0] d, output logic [31:0] rd, output logic er);
        int k;
        @(negedge clk);
        req_valid1 = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_be = 4'hF;
        @(posedge clk);
        #1 req_valid1 = 1'b0;
        for (k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (rsp_valid1) break;
        end
        chk("u1_latency", k, 4);
        rd = rsp_rdata1;
        er = rsp_err1;
    endtask
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
    initial begin
        logic [31:0] rd, a, b;
        logic er;
        logic seen;
        time t1, t2;
        rst0_n = 1'b0; rst1_n = 1'b0; req_valid0 = 1'b0; req_valid1 = 1'b0;
        req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
        tv.push_back(mk(1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 0, 1, 8'h00, 0, 32'h0));
        tv.push_back(mk(0, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF, 0, 1, 8'h00, 0, 32'h0));
        tv.push_back(mk(1, 32'h0, 32'h12345678, 4'hF, 32'h0, 0, 1, 8'h00, 0, 32'h0));
        tv.push_back(mk(0, 32'h3, 32'h0, 4'hF, 32'h0, 1, 1, 8'h00, 0, 32'h0));
        tv.push_back(mk(0, 32'h1000, 32'h0, 4'hF, 32'h0, 1, 1, 8'h00, 0, 32'h0));
        tv.push_back(mk(1, 32'h3, 32'hFFFFFFFF, 4'hF, 32'h0, 1, 1, 8'h00, 0, 32'h0));
        tv.push_back(mk(1, 32'h1000, 32'hFFFFFFFF, 4'hF, 32'h0, 1, 1, 8'h00, 0, 32'h0));
        tv.push_back(mk(0, 32'h0, 32'h0, 4'hF, 32'h12345678, 0, 1, 8'h00, 0, 32'h0));
        tv.push_back(mk(1, MB, 32'h1A5, 4'h0, 32'h0, 0, 1, 8'hA5, 0, 32'h0));
        tv.push_back(mk(0, MB, 32'h0, 4'hF, 32'hA5, 0, 1, 8'hA5, 0, 32'h0));
        tv.push_back(mk(1, MB + 8, 32'h2A, 4'hF, 32'h0, 0, 1, 8'hA5, 1, 32'h2A));
        tv.push_back(mk(0, MB + 8, 32'h0, 4'hF, 32'h2A, 0, 1, 8'hA5, 1, 32'h2A));
        tv.push_back(mk(1, MB + 8, 32'h7, 4'hF, 32'h0, 0, 1, 8'hA5, 1, 32'h7));
        tv.push_back(mk(0, MB + 8, 32'h0, 4'hF, 32'h7, 0, 1, 8'hA5, 1, 32'h7));
        tv.push_back(mk(0, MB + 32'hC, 32'h0, 4'hF, 32'h0, 1, 1, 8'hA5, 1, 32'h7));
        tv.push_back(mk(1, MB + 4, 32'h55, 4'hF, 32'h0, 0, 1, 8'hA5, 1, 32'h7));
        tv.push_back(mk(1, MB + 1, 32'h77, 4'hF, 32'h0, 1, 1, 8'hA5, 1, 32'h7));
        tv.push_back(mk(0, 32'h4000_0000, 32'h0, 4'hF, 32'h0, 1, 1, 8'hA5, 1, 32'h7));
        tv.push_back(mk(0, MB + 32'h10, 32'h0, 4'hF, 32'h0, 1, 1, 8'hA5, 1, 32'h7));
        tv.push_back(mk(1, 32'h20, 32'h11223344, 4'hF, 32'h0, 0, 1, 8'hA5, 1, 32'h7));
        tv.push_back(mk(1, 32'h20, 32'hAABBCCDD, 4'b0101, 32'h0, 0, 1, 8'hA5, 1, 32'h7));
        tv.push_back(mk(0, 32'h20, 32'h0, 4'hF, BE_EXP, 0, 1, 8'hA5, 1, 32'h7));
        tv.push_back(mk(1, 32'hFFC, 32'hCAFEBABE, 4'hF, 32'h0, 0, 1, 8'hA5, 1, 32'h7));
        tv.push_back(mk(0, 32'hFFC, 32'h0, 4'hF, 32'hCAFEBABE, 0, 1, 8'hA5, 1, 32'h7));
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(req_ready0), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid0), 32'd0);
        chk("rst_rdata", rsp_rdata0, 32'd0);
        chk("rst_err", 32'(rsp_err0), 32'd0);
        chk("rst_led", 32'(dbg_led0), 32'd0);
        chk("rst_halt", 32'(halt0), 32'd0);
        chk("rst_code", halt_code0, 32'd0);
        chk("rst_u1_ready", 32'(req_ready1), 32'd1);
        rst0_n = 1'b1; rst1_n = 1'b1;
        foreach (tv[i]) begin
            tv[i].id = i;
            xact(tv[i], rd, t1);
        end
        xact(mk(0, MB + 4, 32'h0, 4'hF, 32'h0, 0, 0, 8'hA5, 1, 32'h7), a, t1);
        repeat (5) @(negedge clk);
        xact(mk(0, MB + 4, 32'h0, 4'hF, 32'h0, 0, 0, 8'hA5, 1, 32'h7), b, t2);
        chk("cycle_delta", b - a, 32'((t2 - t1) / 10));
        @(negedge clk);
        force u0.cyc_cnt = 32'hFFFF_FFFE;
        #1 release u0.cyc_cnt;
        xact(mk(0, MB + 4, 32'h0, 4'hF, 32'h0, 0, 0, 8'hA5, 1, 32'h7), a, t1);
        xact(mk(0, MB + 4, 32'h0, 4'hF, 32'h0, 0, 0, 8'hA5, 1, 32'h7), b, t2);
        chk("wrap_delta", b - a, 32'((t2 - t1) / 10));
        chk("wrap_near_max", 32'(a >= 32'hFFFF_FFF0), 32'd1);
        chk("wrap_seen", 32'(b < a), 32'd1);
        u1_op(1, 32'h40, 32'h0BADF00D, rd, er);
        u1_op(1, MB, 32'h3C, rd, er);
        u1_op(1, MB + 8, 32'h99, rd, er);
        chk("u1_led_pre", 32'(dbg_led1), 32'h3C);
        @(negedge clk);
        req_valid1 = 1'b1; req_we = 1'b1; req_addr = 32'h40; req_wdata = 32'h55555555; req_be = 4'hF;
        @(posedge clk);
        #1 req_valid1 = 1'b0;
        @(negedge clk);
        rst1_n = 1'b0;
        #1;
        chk("u1_rst_ready", 32'(req_ready1), 32'd1);
        chk("u1_rst_rsp_valid", 32'(rsp_valid1), 32'd0);
        chk("u1_rst_rdata", rsp_rdata1, 32'd0);
        chk("u1_rst_err", 32'(rsp_err1), 32'd0);
        chk("u1_rst_led", 32'(dbg_led1), 32'd0);
        chk("u1_rst_halt", 32'(halt1), 32'd0);
        chk("u1_rst_code", halt_code1, 32'd0);
        seen = 1'b0;
        repeat (2) begin
            @(negedge clk);
            seen |= rsp_valid1;
        end
        rst1_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            seen |= rsp_valid1;
        end
        chk("u1_no_rsp_after_rst", 32'(seen), 32'd0);
        chk("u1_ready_after_rst", 32'(req_ready1), 32'd1);
        u1_op(0, 32'h40, 32'h0, rd, er);
        chk("u1_ram_kept", rd, 32'h0BADF00D);
        chk("u1_ram_kept_err", 32'(er), 32'd0);
        repeat (2) @(negedge clk);
        chk("sb_drained", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/hansen_mem_ctrl.md
Name: hansen_mem_ctrl

Overview:
Memory and MMIO controller directly downstream of the Hansen core's memory port. It accepts one word-sized load/store request at a time over a valid/ready handshake and serves it from an internal word-addressed RAM or a small MMIO register bank (debug LED, cycle counter, halt mailbox). It returns a registered response after a programmable number of wait states, and gives simulations a clean halt signal.

Parameters:
DEPTH_WORDS, 1024, RAM size in 32-bit words (power of two, 16..65536)
WAIT_STATES, 1, extra cycles between acceptance and response (0..7)
MMIO_BASE, 32'h8000_0000, base of the 16-byte MMIO window (low 4 bits must be 0)

Ports:
clk  in  1  clock, all state updates on rising edge
reset_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  controller can accept; 1 only in IDLE
req_we  in  1  1=store, 0=load
req_addr  in  32  byte address
req_wdata  in  32  store data
req_be  in  4  store byte enables, lane i = bits [8i+7:8i]
rsp_valid  out  1  one-cycle response strobe
rsp_rdata  out  32  load data; 0 when rsp_valid=0 or for stores/errors
rsp_err  out  1  access fault; 0 when rsp_valid=0
dbg_led  out  8  MMIO LED register
halt  out  1  sticky halt flag
halt_code  out  32  value written to the halt mailbox

Behaviour:
- Reset (async, reset_n=0): state=IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, dbg_led=0, halt=0, halt_code=0, cycle counter=0. RAM contents are not cleared. A transaction in flight is dropped, and its store is not performed.
- FSM: IDLE -> (req_valid&&req_ready) -> WAIT (if WAIT_STATES>0) or RESP -> IDLE.
  - WAIT counts WAIT_STATES cycles, then moves to RESP.
  - RESP lasts exactly one cycle with rsp_valid=1, then returns to IDLE.
- req_ready = (state==IDLE). Requests are latched at the acceptance edge. Input changes after acceptance are ignored. One transaction is outstanding at most.
- Latency: rsp_valid rises WAIT_STATES+1 cycles after the acceptance edge. Throughput is one transaction per WAIT_STATES+2 cycles.
- Side effects (RAM write, MMIO write) and read sampling occur on the edge entering RESP. rsp_* are registered on that edge.
- Address decode, on the latched address, in priority order:
  1. req_addr[1:0]!=0 -> err=1, no side effect.
  2. addr < DEPTH_WORDS*4 -> RAM, index addr[log2(DEPTH_WORDS)+1:2].
  3. addr[31:4]==MMIO_BASE[31:4] -> MMIO, by offset:
     - +0x0 LED: RW. Write sets dbg_led=wdata[7:0]. Read returns {24'b0,dbg_led}.
     - +0x4 CYCLE: RO. Returns the counter value captured at the acceptance edge. Writes are ignored with err=0.
     - +0x8 HALT: a write sets halt=1 and halt_code=wdata. A later write updates halt_code; halt stays 1 until reset. Read returns halt_code.
     - +0xC: err=1.
  4. Anything else -> err=1.
- Cycle counter: 32-bit, increments every cycle out of reset, wraps 0xFFFF_FFFF -> 0.
- MMIO writes ignore req_be. Stores return rsp_rdata=0.
- A load from a RAM word never written returns whatever the RAM holds (X in simulation). Benches must preload before reading.

Optional Feature:
Macro HANSEN_MEM_BYTE_EN_EN.
- Defined: RAM stores update only lanes whose req_be bit is 1. be=4'b0000 is a successful no-op store.
- Undefined: req_be is ignored and RAM stores write the full word.
- Loads always return the full word in both builds.

Test Plan:
- WAIT_STATES=1: store 0xDEADBEEF to 0x10, then load 0x10 -> rsp_valid exactly 2 cycles after each acceptance, rdata=0xDEADBEEF, err=0; req_ready low for 2 cycles after each accept.
- Load from 0x3 and from 0x0000_1000 (DEPTH_WORDS=1024) -> err=1, rdata=0; RAM word 0 is unchanged.
- Store 0x1A5 to MMIO_BASE+0 -> dbg_led=0xA5. Store 0x2A to MMIO_BASE+8 -> halt=1, halt_code=0x2A. Then store 0x7 to MMIO_BASE+8 -> halt_code=0x7, halt still 1.
- Two loads of MMIO_BASE+4 accepted N cycles apart -> values differ by exactly N. With the counter forced near 0xFFFF_FFFF, observe wrap to 0.
- With the macro defined: word 0x11223344 at 0x20, store 0xAABBCCDD with be=4'b0101 -> load returns 0x11BB33DD. Without the macro -> 0xAABBCCDD.
- Assert reset_n low during WAIT of a store to 0x40 (WAIT_STATES=3) -> no rsp_valid, req_ready=1 after release, 0x40 keeps its old data, and all outputs are at their reset values.
